// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one-entry holding register per producer (ALU,
// MUL/DIV, load unit), round-robin selection among pending entries and a
// registered single-result-per-cycle broadcast onto the CDB.
module cdb_arbiter #(
   parameter int NUM_SRC = 3,
   parameter int TAG_W   = 4,
   parameter int DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [DATA_W-1:0]         cdb_data
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0] hold_v;
   logic [TAG_W-1:0]   hold_tag  [NUM_SRC];
   logic [DATA_W-1:0]  hold_data [NUM_SRC];

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W-1:0]   next_ptr;
   logic [PTR_W-1:0]   scan_idx;
   logic [PTR_W:0]     scan_sum;
   logic               found;
   logic [NUM_SRC-1:0] grant;
   logic [NUM_SRC-1:0] capture;

   // Round-robin scan of pending entries starting at rr_ptr; first hit wins.
   always_comb begin
      grant    = '0;
      winner   = '0;
      found    = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_SRC))
            scan_sum = scan_sum - (PTR_W+1)'(NUM_SRC);
         scan_idx = scan_sum[PTR_W-1:0];
         if (!found && hold_v[scan_idx]) begin
            found           = 1'b1;
            grant[scan_idx] = 1'b1;
            winner          = scan_idx;
         end
      end
   end

   assign next_ptr = (winner == PTR_W'(NUM_SRC-1)) ? '0 : winner + 1'b1;

   // A source may refill in the same cycle its current entry wins the bus.
   assign src_ready = ~hold_v | grant;

   // Tag 0 means "no producer": the handshake completes but nothing is stored.
   always_comb begin
      capture = '0;
      for (int i = 0; i < NUM_SRC; i++)
         capture[i] = src_valid[i] & src_ready[i] & (src_tag[i*TAG_W +: TAG_W] != '0);
   end

   // Holding-register occupancy: flush wins over capture, capture over grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_v <= '0;
      end else if (flush) begin
         hold_v <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (capture[i])
               hold_v[i] <= 1'b1;
            else if (grant[i])
               hold_v[i] <= 1'b0;
         end
      end
   end

   // Holding-register payload; qualified by hold_v so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (capture[i] && !flush) begin
            hold_tag[i]  <= src_tag[i*TAG_W +: TAG_W];
            hold_data[i] <= src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Round-robin pointer advances past the winner; untouched by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (!flush && (|grant))
         rr_ptr <= next_ptr;
   end

   // Registered broadcast; tag/data keep their last value while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
      end else if (flush) begin
         cdb_valid <= 1'b0;
      end else begin
         cdb_valid <= |hold_v;
         if (|hold_v) begin
            cdb_tag  <= hold_tag[winner];
            cdb_data <= hold_data[winner];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized
// traffic, checked against a pending-result scoreboard model.
module tb_cdb_arbiter;

   localparam int N  = 3;
   localparam int TW = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    src_valid;
   logic [N*TW-1:0] src_tag;
   logic [N*DW-1:0] src_data;
   logic [N-1:0]    src_ready;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
      .src_ready(src_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: pending results per producer ----------------
   bit            m_v    [N];
   logic [TW-1:0] m_tag  [N];
   logic [DW-1:0] m_data [N];
   int            m_ptr;
   bit            e_v;
   logic [TW-1:0] e_tag;
   logic [DW-1:0] e_data;

   function automatic int m_winner();
      for (int k = 0; k < N; k++)
         if (m_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] m_ready();
      logic [N-1:0] r;
      int w;
      w = m_winner();
      for (int i = 0; i < N; i++) r[i] = !m_v[i] || (i == w);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_ptr = 0; e_v = 0; e_tag = '0; e_data = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] r;
      int w;
      logic [TW-1:0] t;
      r = m_ready();
      w = m_winner();
      if (flush) begin
         for (int i = 0; i < N; i++) m_v[i] = 0;
         e_v = 0;
      end else begin
         e_v = (w >= 0);
         if (w >= 0) begin
            e_tag = m_tag[w]; e_data = m_data[w];
            m_v[w] = 0;
            m_ptr = (w + 1) % N;
         end
         for (int i = 0; i < N; i++) begin
            t = src_tag[i*TW +: TW];
            if (src_valid[i] && r[i] && t != 0) begin
               m_v[i] = 1; m_tag[i] = t; m_data[i] = src_data[i*DW +: DW];
            end
         end
      end
   endtask

   // Advance one clock: model follows the edge, returns at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic clear_src();
      src_valid = '0; src_tag = '0; src_data = '0; flush = 1'b0;
   endtask

   task automatic set_src(input int i, input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d);
      src_valid[i] = v; src_tag[i*TW +: TW] = t; src_data[i*DW +: DW] = d;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; clear_src(); model_reset();
      #1;
      n_tests++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
         n_fail++;
         $display("FAIL reset_cdb: got v=%b tag=%0d data=%h want 0/0/0", cdb_valid, cdb_tag, cdb_data);
      end
      n_tests++;
      if (src_ready !== 3'b111) begin
         n_fail++; $display("FAIL reset_ready: got %b want 111", src_ready);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (src_ready !== 3'b111 || cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: got ready=%b v=%b want 111/0", src_ready, cdb_valid);
      end
   endtask

   task automatic test_single();
      for (int c = 0; c < 4; c++) begin
         clear_src();
         if (c == 0) set_src(2, 1, 4'd5, 32'hDEADBEEF);
         #1;
         n_tests++;
         if (src_ready !== m_ready()) begin
            n_fail++; $display("FAIL single_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL single_cdb c%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                     c, cdb_valid, cdb_tag, cdb_data, e_v, e_tag, e_data);
         end
         n_tests++;
         if (cdb_valid !== (c == 1) || (c == 1 && (cdb_tag !== 4'd5 || cdb_data !== 32'hDEADBEEF))) begin
            n_fail++;
            $display("FAIL single_directed c%0d: got v=%b tag=%0d data=%h want v=%b tag=5 data=deadbeef",
                     c, cdb_valid, cdb_tag, cdb_data, (c == 1));
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [TW-1:0] want_tag [3];
      want_tag[0] = 4'd1; want_tag[1] = 4'd2; want_tag[2] = 4'd3;
      for (int c = 0; c < 5; c++) begin
         clear_src();
         if (c == 0)
            for (int i = 0; i < N; i++) set_src(i, 1, TW'(i + 1), 32'h1000 + DW'(i));
         #1;
         n_tests++;
         if (src_ready !== m_ready()) begin
            n_fail++; $display("FAIL simul_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL simul_cdb c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, cdb_valid, cdb_tag, e_v, e_tag);
         end
         if (c >= 1 && c <= 3) begin
            n_tests++;
            if (cdb_valid !== 1'b1 || cdb_tag !== want_tag[c-1]) begin
               n_fail++;
               $display("FAIL simul_order c%0d: got v=%b tag=%0d want v=1 tag=%0d", c, cdb_valid, cdb_tag, want_tag[c-1]);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int k0 = 0;
      bit armed = 0;
      int seen = 0;
      int at9 = -1;
      for (int c = 0; c < 12; c++) begin
         clear_src();
         set_src(0, 1, TW'(1 + (k0 % 8)), 32'hA000 + DW'(k0));
         if (c == 2) set_src(1, 1, 4'd9, 32'h99);
         #1;
         n_tests++;
         if (src_ready !== m_ready()) begin
            n_fail++; $display("FAIL fair_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         if (src_ready[0]) k0++;
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL fair_cdb c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, cdb_valid, cdb_tag, e_v, e_tag);
         end
         if (armed && cdb_valid === 1'b1) begin
            seen++;
            if (cdb_tag === 4'd9 && at9 < 0) at9 = seen;
         end
         if (c == 2) armed = 1;
      end
      n_tests++;
      if (at9 < 1 || at9 > 2) begin
         n_fail++; $display("FAIL fair_bound: got tag 9 at broadcast %0d want 1..2", at9);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 6; c++) begin
         clear_src();
         if (c < 4) set_src(2, 1, TW'(4 + c), 32'h2000 + DW'(c));
         #1;
         n_tests++;
         if (src_ready[2] !== 1'b1 || src_ready !== m_ready()) begin
            n_fail++; $display("FAIL stream_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL stream_cdb c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, cdb_valid, cdb_tag, e_v, e_tag);
         end
         if (c >= 1 && c <= 4) begin
            n_tests++;
            if (cdb_valid !== 1'b1 || cdb_tag !== TW'(3 + c)) begin
               n_fail++;
               $display("FAIL stream_order c%0d: got v=%b tag=%0d want v=1 tag=%0d", c, cdb_valid, cdb_tag, 3 + c);
            end
         end
      end
   endtask

   task automatic test_discard_flush();
      for (int c = 0; c < 9; c++) begin
         clear_src();
         if (c == 0) set_src(1, 1, 4'd0, 32'h5555);
         if (c == 3) begin set_src(0, 1, 4'd2, 32'h22); set_src(1, 1, 4'd3, 32'h33); end
         if (c == 4) begin flush = 1'b1; set_src(2, 1, 4'd6, 32'h66); end
         #1;
         n_tests++;
         if (src_ready !== m_ready()) begin
            n_fail++; $display("FAIL flush_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL flush_cdb c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, cdb_valid, cdb_tag, e_v, e_tag);
         end
         n_tests++;
         if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_quiet c%0d: got v=%b tag=%0d want v=0", c, cdb_valid, cdb_tag);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         clear_src();
         for (int i = 0; i < N; i++)
            set_src(i, 1'($urandom_range(0, 1)), TW'($urandom_range(0, 15)), DW'($urandom));
         flush = ($urandom_range(0, 19) == 0);
         #1;
         n_tests++;
         if (src_ready !== m_ready()) begin
            n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, src_ready, m_ready());
         end
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL rand_cdb c%0d: got v=%b tag=%0d data=%h want v=%b tag=%0d data=%h",
                     c, cdb_valid, cdb_tag, cdb_data, e_v, e_tag, e_data);
         end
      end
      clear_src();
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_async_reset();
      clear_src();
      for (int i = 0; i < N; i++) set_src(i, 1, TW'(10 + i), 32'hB000 + DW'(i));
      tick();
      clear_src();
      tick();
      tick();
      n_tests++;
      if (cdb_valid !== 1'b1 || cdb_tag !== e_tag || e_v !== 1'b1) begin
         n_fail++; $display("FAIL areset_pre: got v=%b tag=%0d want v=1 tag=%0d", cdb_valid, cdb_tag, e_tag);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0) begin
         n_fail++;
         $display("FAIL areset_async: got v=%b tag=%0d data=%h want 0/0/0", cdb_valid, cdb_tag, cdb_data);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (src_ready !== 3'b111 || cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL areset_release: got ready=%b v=%b want 111/0", src_ready, cdb_valid);
      end
      for (int c = 0; c < 4; c++) begin
         clear_src();
         if (c == 0) begin set_src(1, 1, 4'd7, 32'h77); set_src(2, 1, 4'd8, 32'h88); end
         #1;
         tick();
         n_tests++;
         if (cdb_valid !== e_v || (e_v && (cdb_tag !== e_tag || cdb_data !== e_data))) begin
            n_fail++;
            $display("FAIL areset_cdb c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, cdb_valid, cdb_tag, e_v, e_tag);
         end
         if (c == 1) begin
            n_tests++;
            if (cdb_valid !== 1'b1 || cdb_tag !== 4'd7) begin
               n_fail++; $display("FAIL areset_first: got v=%b tag=%0d want v=1 tag=7", cdb_valid, cdb_tag);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_fairness();
      test_back_to_back();
      test_discard_flush();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
